// File: rtl/npu_pkg.sv
// Shared definitions for the NPU result-SRAM path: memory geometry and the
// state encoding of the output SRAM arbiter.
package npu_pkg;

    localparam int MAX_ADDR_WIDTH = 13;
    localparam int SRAM_WIDTH_O   = 48;   // 6 x 8-bit results per word

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/output_sram_arbiter_rd_valid_pipe.sv
// Read-return tracker: shifts the read-accept strobe through RD_LATENCY+1
// stages. The second-to-last stage tells the parent when sram_dout holds the
// word to capture; the last stage is the rd_valid strobe itself.
module rd_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic m_axis_aclk,
    input  logic m_axis_aresetn,
    input  logic accept,
    output logic load,
    output logic valid,
    output logic pending
);

    localparam int DEPTH = RD_LATENCY + 1;

    logic [DEPTH-1:0] vld_p;

    // Shift the accept strobe one stage per cycle; reset discards in-flight reads
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[DEPTH-2:0], accept};
        end
    end

    assign load    = vld_p[DEPTH-2];
    assign valid   = vld_p[DEPTH-1];
    assign pending = |vld_p[DEPTH-2:0];

endmodule

// File: rtl/output_sram_arbiter.sv
// Output SRAM arbiter: shares the single-port result SRAM between the compute
// writeback path (writes) and the AXI-Stream output engine (reads). One
// access is granted per cycle; the command to the SRAM is registered and
// read data comes back in order with a fixed-latency valid strobe. Bounded
// bursts keep either side from starving the other.
module output_sram_arbiter #(
    parameter int MAX_ADDR_WIDTH = npu_pkg::MAX_ADDR_WIDTH,
    parameter int SRAM_WIDTH_O   = npu_pkg::SRAM_WIDTH_O,
    parameter int RD_LATENCY     = 1,
    parameter int BURST_MAX      = 8
) (
    input  logic                      m_axis_aclk,
    input  logic                      m_axis_aresetn,
    input  logic                      wr_req,
    input  logic [MAX_ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_WIDTH_O-1:0]   wr_data,
    output logic                      wr_gnt,
    input  logic                      rd_req,
    input  logic [MAX_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_gnt,
    output logic [SRAM_WIDTH_O-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      rd_pending,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [MAX_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_WIDTH_O-1:0]   sram_din,
    input  logic [SRAM_WIDTH_O-1:0]   sram_dout
);

    import npu_pkg::*;

    localparam int                 CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    arb_state_t       state;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_load;

    // Burst counter increment that sticks at the limit
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
    endfunction

    // Grant selection: writes win ties from idle; the current owner keeps the
    // port until its burst is spent, but only if the other side is waiting
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        case (state)
            ARB_WR: begin
                if (wr_req && (!rd_req || burst_cnt < CNT_MAX)) wr_gnt = 1'b1;
                else if (rd_req)                                rd_gnt = 1'b1;
            end
            ARB_RD: begin
                if (rd_req && (!wr_req || burst_cnt < CNT_MAX)) rd_gnt = 1'b1;
                else if (wr_req)                                wr_gnt = 1'b1;
            end
            default: begin
                if (wr_req)      wr_gnt = 1'b1;
                else if (rd_req) rd_gnt = 1'b1;
            end
        endcase
    end

    // Arbiter FSM with burst tracking and the registered SRAM command
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else if (wr_gnt) begin
            state     <= ARB_WR;
            burst_cnt <= (state == ARB_WR) ? sat_inc(burst_cnt) : CNT_ONE;
            sram_en   <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= wr_addr;
            sram_din  <= wr_data;
        end else if (rd_gnt) begin
            state     <= ARB_RD;
            burst_cnt <= (state == ARB_RD) ? sat_inc(burst_cnt) : CNT_ONE;
            sram_en   <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= rd_addr;
        end else begin
            // Address and write data hold so the SRAM pins stay quiet when idle
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
        end
    end

    rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_valid_pipe (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .accept         (rd_gnt),
        .load           (rd_load),
        .valid          (rd_valid),
        .pending        (rd_pending)
    );

    // Capture the SRAM word on the edge that raises rd_valid; hold until the next one
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rd_data <= '0;
        end else if (rd_load) begin
            rd_data <= sram_dout;
        end
    end

endmodule
